// File: rtl/cpu_pkg.sv
// Shared opcodes, branch condition codes, instruction field positions and the
// sequencer state encoding for the fetch/decode/execute/writeback controller.
package cpu_pkg;

  localparam logic [3:0] OP_RR    = 4'h0;
  localparam logic [3:0] OP_CMP   = 4'hB;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_LT = 4'h2;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int EXT_MSB = 7;
  localparam int EXT_LSB = 4;
  localparam int RS_MSB  = 3;
  localparam int RS_LSB  = 0;
  localparam int IMM_MSB = 7;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } state_t;

  // Unlisted condition codes are never taken.
  function automatic logic branch_taken(input logic [3:0] cond,
                                        input logic flag_z,
                                        input logic flag_n);
    logic taken;
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = flag_z;
      COND_NE: taken = ~flag_z;
      COND_LT: taken = flag_n;
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: maps a fetched word to register addresses,
// ALU controls and instruction class flags. The sequencer registers these.
module instr_decode
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REGBITS = 4
) (
  input  logic [DATA_W-1:0]  instr,
  output logic [REGBITS-1:0] src,
  output logic [REGBITS-1:0] dst,
  output logic [3:0]         alu_op,
  output logic               use_imm,
  output logic [DATA_W-1:0]  imm,
  output logic [3:0]         cond,
  output logic [7:0]         disp,
  output logic               writes,
  output logic               is_branch,
  output logic               is_halt
);

  logic [3:0] op;
  logic [3:0] ext;
  logic [DATA_W-1:0] imm_sext;

  assign op       = instr[OP_MSB:OP_LSB];
  assign ext      = instr[EXT_MSB:EXT_LSB];
  assign imm_sext = {{(DATA_W-8){instr[IMM_MSB]}}, instr[IMM_MSB:0]};

  always_comb begin
    src       = instr[RS_MSB:RS_LSB];
    dst       = instr[RD_MSB:RD_LSB];
    cond      = instr[RD_MSB:RD_LSB];
    disp      = instr[IMM_MSB:0];
    alu_op    = 4'h0;
    use_imm   = 1'b0;
    imm       = '0;
    writes    = 1'b0;
    is_branch = 1'b0;
    is_halt   = 1'b0;
    case (op)
      OP_RR: begin
        alu_op = ext;
        writes = (ext != OP_CMP);
      end
      OP_BCOND: begin
        is_branch = 1'b1;
        imm       = imm_sext;
      end
      OP_HALT: begin
        is_halt = 1'b1;
      end
      default: begin
        alu_op  = op;
        use_imm = 1'b1;
        imm     = imm_sext;
        writes  = (op != OP_CMP);
      end
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute/writeback sequencer: owns the PC, fetches
// over req/ack and drives register file addresses and ALU controls.
//
// state     | meaning
// FETCH     | instr_req high until instr_ack, decoded word registered on ack
// DECODE    | register file read addresses presented
// EXECUTE   | ALU operands valid, branch condition sampled
// WRITEBACK | write-enable pulse, PC update
// HALT      | idle until reset
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REGBITS = 4,
  parameter int PC_W    = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               instr_req,
  output logic [PC_W-1:0]    instr_addr,
  input  logic               instr_ack,
  input  logic [DATA_W-1:0]  instr_rdata,
  input  logic               flag_z,
  input  logic               flag_n,
  output logic [REGBITS-1:0] src_addr,
  output logic [REGBITS-1:0] dst_addr,
  output logic               reg_write_en,
  output logic [3:0]         alu_op,
  output logic               use_imm,
  output logic [DATA_W-1:0]  imm,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  state_t state, state_next;

  logic [REGBITS-1:0] dec_src, dec_dst;
  logic [3:0]         dec_alu_op, dec_cond;
  logic               dec_use_imm, dec_writes, dec_is_branch, dec_is_halt;
  logic [DATA_W-1:0]  dec_imm;
  logic [7:0]         dec_disp;

  logic [3:0] cond_q;
  logic [7:0] disp_q;
  logic       writes_q, is_branch_q, is_halt_q, taken_q;
  logic       accept;

  instr_decode #(
    .DATA_W (DATA_W),
    .REGBITS(REGBITS)
  ) u_decode (
    .instr    (instr_rdata),
    .src      (dec_src),
    .dst      (dec_dst),
    .alu_op   (dec_alu_op),
    .use_imm  (dec_use_imm),
    .imm      (dec_imm),
    .cond     (dec_cond),
    .disp     (dec_disp),
    .writes   (dec_writes),
    .is_branch(dec_is_branch),
    .is_halt  (dec_is_halt)
  );

  assign accept = (state == ST_FETCH) && instr_ack;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:     if (instr_ack) state_next = ST_DECODE;
      ST_DECODE:    state_next = ST_EXECUTE;
      ST_EXECUTE:   state_next = ST_WRITEBACK;
      ST_WRITEBACK: state_next = is_halt_q ? ST_HALT : ST_FETCH;
      ST_HALT:      state_next = ST_HALT;
      default:      state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      src_addr    <= '0;
      dst_addr    <= '0;
      alu_op      <= '0;
      use_imm     <= 1'b0;
      imm         <= '0;
      cond_q      <= '0;
      disp_q      <= '0;
      writes_q    <= 1'b0;
      is_branch_q <= 1'b0;
      is_halt_q   <= 1'b0;
      taken_q     <= 1'b0;
    end else begin
      if (accept) begin
        src_addr    <= dec_src;
        dst_addr    <= dec_dst;
        alu_op      <= dec_alu_op;
        use_imm     <= dec_use_imm;
        imm         <= dec_imm;
        cond_q      <= dec_cond;
        disp_q      <= dec_disp;
        writes_q    <= dec_writes;
        is_branch_q <= dec_is_branch;
        is_halt_q   <= dec_is_halt;
      end
      if (state == ST_EXECUTE)
        taken_q <= is_branch_q && branch_taken(cond_q, flag_z, flag_n);
      if (state == ST_WRITEBACK && !is_halt_q) begin
        if (taken_q) pc <= pc + {{(PC_W-8){disp_q[7]}}, disp_q};
        else         pc <= pc + 1'b1;
      end
    end
  end

  // Gating with reset keeps request, write pulse and halted low in the reset cycle
  // whatever state the register still holds.
  assign instr_req    = (state == ST_FETCH) && !reset;
  assign reg_write_en = (state == ST_WRITEBACK) && writes_q && !reset;
  assign halted       = (state == ST_HALT) && !reset;
  assign instr_addr   = pc;

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
- Multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit datapath.
- Sits directly upstream of the register file:
  - fetches instruction words over a req/ack handshake;
  - drives the register file's write enable and both read/write addresses;
  - drives ALU op/immediate controls;
  - owns the PC.
- Register file reads are registered (addresses in cycle N give data in N+1), so the FSM holds addresses stable across DECODE..WRITEBACK.

Parameters:
- DATA_W, 16, datapath/instruction width
- REGBITS, 4, register address width (16 registers)
- PC_W, 16, program counter width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- instr_req  output  1  fetch request, held high until acked
- instr_addr  output  PC_W  fetch address (= pc)
- instr_ack  input  1  fetch complete; instr_rdata valid this cycle
- instr_rdata  input  DATA_W  fetched instruction word
- flag_z  input  1  zero flag from PSR (stable during EXECUTE)
- flag_n  input  1  negative flag from PSR
- src_addr  output  REGBITS  register file source read address
- dst_addr  output  REGBITS  register file destination read/write address
- reg_write_en  output  1  register file write enable (one-cycle pulse)
- alu_op  output  4  ALU operation select
- use_imm  output  1  ALU operand B = imm instead of register data
- imm  output  DATA_W  sign-extended 8-bit immediate
- pc  output  PC_W  current program counter
- halted  output  1  high while in HALT state

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-high.
- Instruction format:
  - [15:12] op
  - [11:8] Rdest/cond
  - [7:4] ext
  - [3:0] Rsrc
  - [7:0] imm/disp
- Decode rules:
  - op=0x0: register-register; alu_op=ext; use_imm=0.
  - op=0xC: Bcond with cond=[11:8]:
    - 0 = EQ (branch if z)
    - 1 = NE (branch if !z)
    - 2 = LT (branch if n)
    - E = always
    - other cond values: never taken
    - no register write
  - op=0xF: HALT.
  - All other op values: immediate form; alu_op=op; use_imm=1; imm=sign-extend([7:0]).
  - CMP (op=0xB, or op=0x0 with ext=0xB): no register write.
- States:
  - FETCH: instr_req=1. On instr_ack, latch instr_rdata and go to DECODE. Wait indefinitely otherwise.
  - DECODE: src_addr/dst_addr driven from the latched instruction; these are the register file's addresses for the read taking effect at this edge. Go to EXECUTE.
  - EXECUTE: read data is now valid at the ALU; alu_op/use_imm/imm are valid; branch condition is sampled from flag_z/flag_n. Go to WRITEBACK.
  - WRITEBACK:
    - reg_write_en=1 for exactly this cycle if the instruction writes.
    - PC update: pc <= pc + sext(disp) if the branch is taken, else pc+1, modulo 2^PC_W.
    - Go to FETCH, or to HALT if op=0xF (HALT does not advance pc).
  - HALT: halted=1; no requests; exited only by reset.
- Output timing:
  - src_addr, dst_addr, alu_op, use_imm and imm are registered.
  - They change only on the edge entering DECODE and stay stable through WRITEBACK.
- Latency: 4 cycles per instruction plus memory wait cycles; a zero-wait fetch acks in the first FETCH cycle.
- Reset values:
  - pc=RESET_PC
  - state=FETCH
  - instr_req=0 in the reset cycle (asserted on the next cycle)
  - reg_write_en=0
  - all address/control outputs=0
  - halted=0
- Reset mid-operation:
  - any in-flight write is suppressed (reg_write_en=0 in the reset cycle);
  - any pending fetch is abandoned; an ack arriving in the reset cycle is ignored.
- instr_ack outside FETCH: ignored.
- Simultaneous ack and reset: reset wins.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants (OP_RR=0x0, OP_CMP=0xB, OP_BCOND=0xC, OP_HALT=0xF);
  - cond codes (EQ, NE, LT, AL);
  - state enum (FETCH, DECODE, EXECUTE, WRITEBACK, HALT);
  - field bit positions.
- Sub-module instr_decode: purely combinational; maps an instruction word to src/dst/alu_op/use_imm/imm/writes/is_branch/is_halt. The FSM registers its outputs on entry to DECODE.

Test Plan:
- Reset, then zero-wait fetch of 0x0153 (RR, ext=5, Rdest=1, Rsrc=3) -> src_addr=3, dst_addr=1, alu_op=5, use_imm=0; reg_write_en pulses in cycle 4; pc becomes 1.
- Fetch 0x52FF (op 5, imm) -> use_imm=1, imm=0xFFFF, dst_addr=2; write pulse; pc+1.
- Bcond EQ 0xC0FC at pc=0x10 with flag_z=1 -> no write, pc=0x0C; repeat with flag_z=0 -> pc=0x11.
- instr_ack withheld for 5 cycles -> instr_req stays 1 with instr_addr unchanged; all other outputs hold; then normal completion.
- HALT 0xF000 -> halted=1, instr_req=0 forever, pc unchanged; a later reset resumes at RESET_PC.
- reset asserted in WRITEBACK of a writing instruction -> reg_write_en=0 that cycle; pc=RESET_PC next cycle.
